// File: rtl/tlc_phase_controller_pkg.sv
// Shared types and constants for the phase-based traffic-light controller.
package light_package;

    typedef enum logic [1:0] {
        red    = 2'b00,
        yellow = 2'b01,
        green  = 2'b10
    } colors;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        ALL_RED = 2'd3
    } tlc_state_e;

    localparam int E_LEFT = 0;
    localparam int E_STR  = 1;
    localparam int W_LEFT = 2;
    localparam int W_STR  = 3;
    localparam int NS     = 4;

    // Index p of the packed array is phase p: P0 e/w straight, P1 e/w left,
    // P2 east both, P3 west both, P4 north-south.
    localparam logic [4:0][4:0] DEFAULT_PHASE_MASK =
        {5'b10000, 5'b01100, 5'b00011, 5'b00101, 5'b01010};

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tlc_phase_controller_arbiter.sv
// Round-robin first-match search: scans req starting at ptr+1, wrapping modulo N.
module tlc_rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    logic [PW-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest candidate back to the nearest so the nearest match wins.
        for (int i = N; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_phase_controller.sv
// Phase-based traffic-light controller: round-robin service of demanded phases with
// min/max green, yellow and all-red timing. Optional preemption: TLC_PREEMPT_EN.
module tlc_phase_controller
    import light_package::*;
#(
    parameter int NUM_LIGHTS     = 5,
    parameter int NUM_PHASES     = 5,
    parameter logic [NUM_PHASES-1:0][NUM_LIGHTS-1:0] PHASE_MASK = DEFAULT_PHASE_MASK,
    parameter int GREEN_MIN      = 5,
    parameter int GREEN_MAX      = 10,
    parameter int YELLOW_CYCLES  = 2,
    parameter int ALL_RED_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_LIGHTS-1:0]            sensor_i,
    output logic [NUM_LIGHTS-1:0][1:0]       light_o,
    output logic [$clog2(NUM_PHASES)-1:0]    phase_o,
    output logic                             phase_valid_o
`ifdef TLC_PREEMPT_EN
    ,
    input  logic                             preempt_i,
    input  logic [$clog2(NUM_PHASES)-1:0]    preempt_phase_i
`endif
);

    localparam int PW = $clog2(NUM_PHASES);
    localparam int CW = $clog2(max3(GREEN_MAX, YELLOW_CYCLES, ALL_RED_CYCLES) + 1);

    if (GREEN_MIN < 1) begin : g_chk_gmin
        $error("GREEN_MIN must be at least 1");
    end
    if (GREEN_MAX < GREEN_MIN) begin : g_chk_gmax
        $error("GREEN_MAX must not be below GREEN_MIN");
    end
    if (YELLOW_CYCLES < 1) begin : g_chk_yel
        $error("YELLOW_CYCLES must be at least 1");
    end
    if (ALL_RED_CYCLES < 1) begin : g_chk_ar
        $error("ALL_RED_CYCLES must be at least 1");
    end
    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_chk_mask
        if (PHASE_MASK[p] == '0) begin : g_err
            $error("PHASE_MASK entry %0d is empty", p);
        end
    end

    tlc_state_e          state_q, state_d;
    logic [PW-1:0]       cur_q, cur_d;
    logic [PW-1:0]       last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_PHASES-1:0] req;
    logic [PW-1:0]       arb_grant;
    logic                arb_valid;
    logic [PW-1:0]       sel_phase;
    logic                sel_valid;
    logic                force_yellow;
    logic                hold_green;
    logic [NUM_LIGHTS-1:0] cur_mask;
    logic                own_demand;
    logic                other_demand;

    always_comb begin
        req = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            req[p] = |(sensor_i & PHASE_MASK[p]);
        end
    end

    tlc_rr_arbiter #(
        .N  (NUM_PHASES),
        .PW (PW)
    ) u_arb (
        .req   (req),
        .ptr   (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

`ifdef TLC_PREEMPT_EN
    assign sel_valid    = preempt_i | arb_valid;
    assign sel_phase    = preempt_i ? preempt_phase_i : arb_grant;
    assign force_yellow = preempt_i && (cur_q != preempt_phase_i);
    assign hold_green   = preempt_i && (cur_q == preempt_phase_i);
`else
    assign sel_valid    = arb_valid;
    assign sel_phase    = arb_grant;
    assign force_yellow = 1'b0;
    assign hold_green   = 1'b0;
`endif

    assign cur_mask     = PHASE_MASK[cur_q];
    assign own_demand   = |(sensor_i & cur_mask);
    assign other_demand = |(sensor_i & ~cur_mask);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = GREEN;
                    cur_d   = sel_phase;
                    last_d  = sel_phase;
                    cnt_d   = CW'(1);
                end
            end
            GREEN: begin
                if (cnt_q < CW'(GREEN_MAX)) cnt_d = cnt_q + CW'(1);
                if (!hold_green &&
                    (force_yellow ||
                     (cnt_q >= CW'(GREEN_MIN) && !own_demand) ||
                     (cnt_q >= CW'(GREEN_MAX) && other_demand))) begin
                    state_d = YELLOW;
                    cnt_d   = CW'(1);
                end
            end
            YELLOW: begin
                if (cnt_q >= CW'(YELLOW_CYCLES)) begin
                    state_d = ALL_RED;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ALL_RED: begin
                if (cnt_q < CW'(ALL_RED_CYCLES)) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (sel_valid) begin
                    state_d = GREEN;
                    cur_d   = sel_phase;
                    last_d  = sel_phase;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= PW'(NUM_PHASES - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are a registered decode of the state, so lights trail the state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            light_o       <= '0;
            phase_o       <= '0;
            phase_valid_o <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                if (state_q == GREEN && cur_mask[i])       light_o[i] <= green;
                else if (state_q == YELLOW && cur_mask[i]) light_o[i] <= yellow;
                else                                       light_o[i] <= red;
            end
            phase_o       <= cur_q;
            phase_valid_o <= (state_q == GREEN) || (state_q == YELLOW);
        end
    end

endmodule

// File: tb/tb_tlc_phase_controller.sv
// Scoreboard bench for tlc_phase_controller: per-cycle expected lights/phase are queued
// with the stimulus and drained one entry per clock.
module tb_tlc_phase_controller;

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;
    localparam logic [4:0][4:0] MASK = {5'b10000, 5'b01100, 5'b00011, 5'b00101, 5'b01010};

    typedef struct packed {
        logic [9:0] lights;
        logic       valid;
        logic [2:0] phase;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      sensor;
    logic [4:0][1:0] light_o;
    logic [2:0]      phase_o;
    logic            phase_valid;
`ifdef TLC_PREEMPT_EN
    logic            preempt;
    logic [2:0]      preempt_phase;
`endif

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    string cur_test = "";

    always #5 clk = ~clk;

    tlc_phase_controller dut (
        .clk           (clk),
        .reset         (reset),
        .sensor_i      (sensor),
        .light_o       (light_o),
        .phase_o       (phase_o),
        .phase_valid_o (phase_valid)
`ifdef TLC_PREEMPT_EN
        ,
        .preempt_i       (preempt),
        .preempt_phase_i (preempt_phase)
`endif
    );

    function automatic logic [9:0] lights_of(input logic [2:0] ph, input logic [1:0] col);
        logic [9:0] r;
        logic [4:0] m;
        r = '0;
        m = MASK[ph];
        for (int i = 0; i < 5; i++) begin
            if (m[i]) r[2*i +: 2] = col;
        end
        return r;
    endfunction

    function automatic logic conflict(input logic [9:0] l);
        logic [4:0] g;
        for (int i = 0; i < 5; i++) g[i] = (l[2*i +: 2] == C_GRN);
        return (g[0] && (g[3] || g[4])) || (g[2] && (g[1] || g[4])) ||
               (g[1] && g[4]) || (g[3] && g[4]);
    endfunction

    task automatic push(input logic [1:0] col, input logic valid, input logic [2:0] ph, input int n);
        exp_t e;
        e.lights = lights_of(ph, col);
        e.valid  = valid;
        e.phase  = ph;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic sb_step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (conflict(light_o) !== 1'b0) begin
            errors++;
            $display("FAIL %s.conflict cyc=%0d got lights=%h required no conflicting greens", cur_test, cyc, light_o);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.sb_underflow cyc=%0d got empty queue required an expectation", cur_test, cyc);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (light_o !== e.lights) begin
                errors++;
                $display("FAIL %s.lights cyc=%0d got=%h required=%h", cur_test, cyc, light_o, e.lights);
            end
            checks++;
            if (phase_valid !== e.valid) begin
                errors++;
                $display("FAIL %s.valid cyc=%0d got=%b required=%b", cur_test, cyc, phase_valid, e.valid);
            end
            checks++;
            if (phase_o !== e.phase) begin
                errors++;
                $display("FAIL %s.phase cyc=%0d got=%0d required=%0d", cur_test, cyc, phase_o, e.phase);
            end
        end
    endtask

    task automatic sb_drained();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s.leftover got=%0d entries required=0", cur_test, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        sensor = '0;
`ifdef TLC_PREEMPT_EN
        preempt       = 1'b0;
        preempt_phase = '0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        reset  = 1'b1;
        sensor = '0;
`ifdef TLC_PREEMPT_EN
        preempt       = 1'b0;
        preempt_phase = '0;
`endif
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (light_o !== 10'h000) begin
                errors++;
                $display("FAIL reset.hold_lights got=%h required=000", light_o);
            end
            checks++;
            if (phase_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset.hold_valid got=%b required=0", phase_valid);
            end
        end
        reset = 1'b0;
        push(C_RED, 1'b0, 3'd0, 20);
        repeat (20) sb_step();
        sb_drained();
    endtask

    task automatic test_single_demand();
        cur_test = "single_demand";
        apply_reset();
        sensor = 5'b00001;
        push(C_RED, 1'b0, 3'd0, 1);
        push(C_GRN, 1'b1, 3'd1, 5);
        push(C_YEL, 1'b1, 3'd1, 2);
        push(C_RED, 1'b0, 3'd1, 4);
        repeat (3) sb_step();
        sensor = '0;
        repeat (9) sb_step();
        sb_drained();
    endtask

    task automatic test_max_green();
        cur_test = "max_green";
        apply_reset();
        sensor = 5'b10000;
        push(C_RED, 1'b0, 3'd0, 1);
        push(C_GRN, 1'b1, 3'd4, 10);
        push(C_YEL, 1'b1, 3'd4, 2);
        push(C_RED, 1'b0, 3'd4, 1);
        push(C_GRN, 1'b1, 3'd1, 10);
        push(C_YEL, 1'b1, 3'd1, 2);
        push(C_RED, 1'b0, 3'd1, 1);
        push(C_GRN, 1'b1, 3'd2, 1);
        repeat (4) sb_step();
        sensor = 5'b10001;
        repeat (24) sb_step();
        sb_drained();
    endtask

    task automatic test_all_five();
        cur_test = "all_five";
        apply_reset();
        sensor = 5'b11111;
        push(C_RED, 1'b0, 3'd0, 1);
        for (int p = 0; p < 5; p++) begin
            push(C_GRN, 1'b1, 3'(p), 10);
            push(C_YEL, 1'b1, 3'(p), 2);
            push(C_RED, 1'b0, 3'(p), 1);
        end
        push(C_GRN, 1'b1, 3'd0, 1);
        repeat (67) sb_step();
        sb_drained();
    endtask

    task automatic test_reset_mid_yellow();
        cur_test = "reset_mid_yellow";
        apply_reset();
        sensor = 5'b11111;
        push(C_RED, 1'b0, 3'd0, 1);
        push(C_GRN, 1'b1, 3'd0, 10);
        push(C_YEL, 1'b1, 3'd0, 1);
        repeat (12) sb_step();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (light_o !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid_yellow.async_lights got=%h required=000", light_o);
        end
        checks++;
        if (phase_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_yellow.async_valid got=%b required=0", phase_valid);
        end
        checks++;
        if (phase_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_yellow.async_phase got=%0d required=0", phase_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(C_RED, 1'b0, 3'd0, 1);
        push(C_GRN, 1'b1, 3'd0, 10);
        push(C_YEL, 1'b1, 3'd0, 2);
        push(C_RED, 1'b0, 3'd0, 1);
        push(C_GRN, 1'b1, 3'd1, 1);
        repeat (15) sb_step();
        sb_drained();
    endtask

`ifdef TLC_PREEMPT_EN
    task automatic test_preempt();
        cur_test = "preempt";
        apply_reset();
        sensor = 5'b10000;
        push(C_RED, 1'b0, 3'd0, 1);
        push(C_GRN, 1'b1, 3'd4, 3);
        push(C_YEL, 1'b1, 3'd4, 2);
        push(C_RED, 1'b0, 3'd4, 1);
        push(C_GRN, 1'b1, 3'd0, 16);
        push(C_YEL, 1'b1, 3'd0, 2);
        push(C_RED, 1'b0, 3'd0, 1);
        push(C_GRN, 1'b1, 3'd4, 1);
        repeat (3) sb_step();
        preempt       = 1'b1;
        preempt_phase = 3'd0;
        repeat (19) sb_step();
        preempt = 1'b0;
        repeat (5) sb_step();
        sb_drained();
    endtask
`endif

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_single_demand();
        test_max_green();
        test_all_five();
        test_reset_mid_yellow();
`ifdef TLC_PREEMPT_EN
        test_preempt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
